// File: rtl/pool_pkg.sv
// Shared types and helpers for the pooling engine: FSM states, mode encoding
// and the power-of-two window check used by average mode.
package pool_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    ACC,
    WR,
    DONE
  } pool_state_e;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  typedef struct packed {
    logic       is_pow2;
    logic [3:0] shift;
  } pow2_t;

  // Window element count -> shift amount for the average divide.
  function automatic pow2_t log2_pow2(input logic [7:0] v);
    pow2_t r;
    r.is_pow2 = (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    r.shift   = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r.shift = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Window walker: four nested counters (element column/row inside a window,
// window column/row across the matrix) and the read/write address math.
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DIM_W      = 8,
  parameter int WIN_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  restart,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] rd_base,
  input  logic [ADDR_WIDTH-1:0] wr_base,
  input  logic [DIM_W-1:0]      cols,
  input  logic [DIM_W-1:0]      out_rows,
  input  logic [DIM_W-1:0]      out_cols,
  input  logic [WIN_W-1:0]      win_m,
  input  logic [WIN_W-1:0]      win_n,
  output logic                  last_elem,
  output logic                  last_win,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] wr_addr
);

  logic [WIN_W-1:0]      wc_i;
  logic [WIN_W-1:0]      wr_i;
  logic [DIM_W-1:0]      out_c;
  logic [DIM_W-1:0]      out_r;
  logic                  last_wc;
  logic                  last_wr;
  logic                  last_oc;
  logic                  last_or;
  logic [ADDR_WIDTH-1:0] row_a;
  logic [ADDR_WIDTH-1:0] col_a;

  assign last_wc   = (wc_i == win_n - WIN_W'(1));
  assign last_wr   = (wr_i == win_m - WIN_W'(1));
  assign last_oc   = (out_c == out_cols - DIM_W'(1));
  assign last_or   = (out_r == out_rows - DIM_W'(1));
  assign last_elem = last_wc && last_wr;
  assign last_win  = last_oc && last_or;

  // Stepping past the final element of a window rolls into the next window;
  // the outermost counter wraps so the block is clean for the next job.
  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      wc_i  <= '0;
      wr_i  <= '0;
      out_c <= '0;
      out_r <= '0;
    end else if (step) begin
      if (!last_wc) begin
        wc_i <= wc_i + WIN_W'(1);
      end else begin
        wc_i <= '0;
        if (!last_wr) begin
          wr_i <= wr_i + WIN_W'(1);
        end else begin
          wr_i <= '0;
          if (!last_oc) begin
            out_c <= out_c + DIM_W'(1);
          end else begin
            out_c <= '0;
            out_r <= last_or ? '0 : out_r + DIM_W'(1);
          end
        end
      end
    end
  end

  // All products truncate to ADDR_WIDTH, so addresses wrap modulo the space.
  assign row_a   = ADDR_WIDTH'(out_r) * ADDR_WIDTH'(win_m) + ADDR_WIDTH'(wr_i);
  assign col_a   = ADDR_WIDTH'(out_c) * ADDR_WIDTH'(win_n) + ADDR_WIDTH'(wc_i);
  assign rd_addr = rd_base + row_a * ADDR_WIDTH'(cols) + col_a;
  assign wr_addr = wr_base + ADDR_WIDTH'(out_r) * ADDR_WIDTH'(out_cols) + ADDR_WIDTH'(out_c);

endmodule

// File: rtl/pool_engine.sv
// Max/average pooling engine: one read outstanding at a time, one write per
// window, with start-time configuration checking and done/error pulses.
module pool_engine
  import pool_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_W     = 8,
  parameter int DIM_W      = 8,
  parameter int MAX_WIN    = 4,
  parameter int WIN_W      = $clog2(MAX_WIN + 1),
  parameter int ACC_W      = DATA_W + 2 * $clog2(MAX_WIN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sw_start,
  input  logic [ADDR_WIDTH-1:0] sw_rd_addr,
  input  logic [ADDR_WIDTH-1:0] sw_wr_addr,
  input  logic [DIM_W-1:0]      sw_rows,
  input  logic [DIM_W-1:0]      sw_cols,
  input  logic [WIN_W-1:0]      sw_win_m,
  input  logic [WIN_W-1:0]      sw_win_n,
  input  logic                  sw_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_gnt,
  input  logic                  rd_valid,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_gnt
);

  pool_state_e state, state_nxt;

  logic [ADDR_WIDTH-1:0] rd_base_q;
  logic [ADDR_WIDTH-1:0] wr_base_q;
  logic [DIM_W-1:0]      cols_q;
  logic [DIM_W-1:0]      out_rows_q;
  logic [DIM_W-1:0]      out_cols_q;
  logic [WIN_W-1:0]      win_m_q;
  logic [WIN_W-1:0]      win_n_q;
  logic                  mode_q;
  logic [3:0]            shift_q;
  logic [DATA_W-1:0]     rd_data_q;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] elem_ext;
  logic signed [ACC_W-1:0] avg_res;
  logic                  win_first;

  pow2_t                 win_pow2;
  logic                  cfg_ok;
  logic                  start_ok;
  logic                  start_bad;
  logic                  step;
  logic                  last_elem;
  logic                  last_win;
  logic [ADDR_WIDTH-1:0] gen_rd_addr;
  logic [ADDR_WIDTH-1:0] gen_wr_addr;

  assign win_pow2 = log2_pow2(8'(sw_win_m) * 8'(sw_win_n));
  assign cfg_ok   = (sw_win_m != '0) && (sw_win_n != '0)
                 && (sw_win_m <= WIN_W'(MAX_WIN)) && (sw_win_n <= WIN_W'(MAX_WIN))
                 && (sw_rows >= DIM_W'(sw_win_m)) && (sw_cols >= DIM_W'(sw_win_n))
                 && ((sw_mode == POOL_MAX) || win_pow2.is_pow2);
  assign start_ok  = (state == IDLE) && sw_start && cfg_ok;
  assign start_bad = (state == IDLE) && sw_start && !cfg_ok;

  // The final element of a window does not step; the write still needs that
  // window's coordinates, so the walk advances on the write grant instead.
  assign step = ((state == ACC) && !last_elem) || ((state == WR) && wr_gnt);

  pool_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DIM_W     (DIM_W),
    .WIN_W     (WIN_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (start_ok),
    .step     (step),
    .rd_base  (rd_base_q),
    .wr_base  (wr_base_q),
    .cols     (cols_q),
    .out_rows (out_rows_q),
    .out_cols (out_cols_q),
    .win_m    (win_m_q),
    .win_n    (win_n_q),
    .last_elem(last_elem),
    .last_win (last_win),
    .rd_addr  (gen_rd_addr),
    .wr_addr  (gen_wr_addr)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok) state_nxt = RD_REQ;
      RD_REQ:  if (rd_gnt) state_nxt = RD_WAIT;
      RD_WAIT: if (rd_valid) state_nxt = ACC;
      ACC:     state_nxt = last_elem ? WR : RD_REQ;
      WR:      if (wr_gnt) state_nxt = last_win ? DONE : RD_REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign elem_ext = {{(ACC_W - DATA_W){rd_data_q[DATA_W-1]}}, rd_data_q};
  assign avg_res  = acc >>> shift_q;

  // NOTE: every output gets a default before the case, so no path through
  // this block can leave a signal unassigned and infer a latch.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    unique case (state)
      RD_REQ: begin
        busy    = 1'b1;
        rd_req  = 1'b1;
        rd_addr = gen_rd_addr;
      end
      RD_WAIT, ACC: busy = 1'b1;
      WR: begin
        busy    = 1'b1;
        wr_req  = 1'b1;
        wr_addr = gen_wr_addr;
        wr_data = (mode_q == POOL_AVG) ? avg_res[DATA_W-1:0] : acc[DATA_W-1:0];
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_base_q  <= '0;
      wr_base_q  <= '0;
      cols_q     <= '0;
      out_rows_q <= '0;
      out_cols_q <= '0;
      win_m_q    <= '0;
      win_n_q    <= '0;
      mode_q     <= POOL_MAX;
      shift_q    <= '0;
      rd_data_q  <= '0;
      acc        <= '0;
      win_first  <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= start_bad;
      if (start_ok) begin
        rd_base_q  <= sw_rd_addr;
        wr_base_q  <= sw_wr_addr;
        cols_q     <= sw_cols;
        out_rows_q <= sw_rows / DIM_W'(sw_win_m);
        out_cols_q <= sw_cols / DIM_W'(sw_win_n);
        win_m_q    <= sw_win_m;
        win_n_q    <= sw_win_n;
        mode_q     <= sw_mode;
        shift_q    <= win_pow2.shift;
        win_first  <= 1'b1;
      end
      if ((state == RD_WAIT) && rd_valid) rd_data_q <= rd_data;
      if (state == ACC) begin
        win_first <= 1'b0;
        if (win_first)                acc <= elem_ext;
        else if (mode_q == POOL_AVG)  acc <= acc + elem_ext;
        else if (elem_ext > acc)      acc <= elem_ext;
      end
      if ((state == WR) && wr_gnt) win_first <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pool_engine.sv
// Directed bench for pool_engine: a table of job vectors with hand-computed
// first/last results, a behavioural memory with optional stalls, and a model.
module tb_pool_engine;

  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sw_start = 1'b0;
  logic [AW-1:0] sw_rd_addr = '0;
  logic [AW-1:0] sw_wr_addr = '0;
  logic [7:0]    sw_rows = '0;
  logic [7:0]    sw_cols = '0;
  logic [2:0]    sw_win_m = '0;
  logic [2:0]    sw_win_n = '0;
  logic          sw_mode = 1'b0;
  logic          busy, done, cfg_err, rd_req, wr_req;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_gnt = 1'b0;
  logic          rd_valid = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic          wr_gnt = 1'b0;

  always #5 clk = ~clk;

  pool_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_start  (sw_start),
    .sw_rd_addr(sw_rd_addr),
    .sw_wr_addr(sw_wr_addr),
    .sw_rows   (sw_rows),
    .sw_cols   (sw_cols),
    .sw_win_m  (sw_win_m),
    .sw_win_n  (sw_win_n),
    .sw_mode   (sw_mode),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int rows, cols, wm, wn, mode, rb, wb, fill, stall;
    int exp_err, exp_nwr, exp_first, exp_last;
  } vec_t;

  // Memory model: grant decisions and read returns change on the falling edge.
  logic signed [7:0] mem [0:4095];
  int rd_q[$];
  int wa_q[$];
  int wd_q[$];
  bit stall_en = 1'b0;
  int lat_cfg  = 1;
  int rd_cnt   = 0;
  int rd_paddr = 0;
  bit rd_hs    = 1'b0;
  int rd_hs_addr = 0;
  bit rd_hold  = 1'b0;
  int rd_hold_addr = 0;
  bit wr_hold  = 1'b0;
  int wr_hold_addr = 0;
  int wr_hold_data = 0;
  bit prev_rst = 1'b0;

  always @(negedge clk) begin
    rd_valid = 1'b0;
    if (rd_hs) begin
      rd_paddr = rd_hs_addr;
      rd_cnt   = stall_en ? int'($urandom_range(1, 5)) : lat_cfg;
    end
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        rd_valid = 1'b1;
        rd_data  = mem[rd_paddr];
      end
    end
    if (rd_hold && prev_rst) begin
      check("rd_req_held", int'(rd_req), 1);
      check("rd_addr_stable", int'(rd_addr), rd_hold_addr);
    end
    if (wr_hold && prev_rst) begin
      check("wr_req_held", int'(wr_req), 1);
      check("wr_addr_stable", int'(wr_addr), wr_hold_addr);
      check("wr_data_stable", int'(wr_data), wr_hold_data);
    end
    rd_gnt = rd_req && (!stall_en || ($urandom_range(0, 2) == 0));
    wr_gnt = wr_req && (!stall_en || ($urandom_range(0, 2) == 0));
    rd_hs      = rd_req && rd_gnt;
    rd_hs_addr = int'(rd_addr);
    if (rd_hs && rst_n) rd_q.push_back(int'(rd_addr));
    if (wr_req && wr_gnt && rst_n) begin
      wa_q.push_back(int'(wr_addr));
      wd_q.push_back(int'($signed(wr_data)));
    end
    rd_hold      = rd_req && !rd_gnt;
    rd_hold_addr = int'(rd_addr);
    wr_hold      = wr_req && !wr_gnt;
    wr_hold_addr = int'(wr_addr);
    wr_hold_data = int'(wr_data);
    prev_rst     = rst_n;
  end

  function automatic int fill_val(input int kind, input int i);
    case (kind)
      0:       return i;
      1:       return (i == 0) ? -2 : -3;
      2:       return -(i + 1) * 5;
      default: return ((i * 37) % 256) - 128;
    endcase
  endfunction

  task automatic start_job(input vec_t v);
    @(posedge clk); #1;
    sw_rd_addr = AW'(v.rb);
    sw_wr_addr = AW'(v.wb);
    sw_rows    = 8'(v.rows);
    sw_cols    = 8'(v.cols);
    sw_win_m   = 3'(v.wm);
    sw_win_n   = 3'(v.wn);
    sw_mode    = 1'(v.mode);
    sw_start   = 1'b1;
    @(posedge clk); #1;
    sw_start   = 1'b0;
  endtask

  task automatic run_job(input vec_t v, input int idx, input bit repulse);
    int exp_rd[$];
    int exp_wa[$];
    int exp_wd[$];
    int orows, ocols, n, sh, acc, e, a, cyc, gaps, seen;
    string tag;
    tag = $sformatf("v%0d", idx);
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    for (int i = 0; i < v.rows * v.cols; i++) mem[(v.rb + i) & 'hFFF] = 8'(fill_val(v.fill, i));
    if (v.exp_err == 0) begin
      orows = v.rows / v.wm;
      ocols = v.cols / v.wn;
      n  = v.wm * v.wn;
      sh = 0;
      while ((1 << sh) < n) sh++;
      for (int orr = 0; orr < orows; orr++) begin
        for (int occ = 0; occ < ocols; occ++) begin
          acc = 0;
          for (int i = 0; i < v.wm; i++) begin
            for (int j = 0; j < v.wn; j++) begin
              a = (v.rb + (orr * v.wm + i) * v.cols + occ * v.wn + j) & 'hFFF;
              exp_rd.push_back(a);
              e = int'(mem[a]);
              if (i == 0 && j == 0) acc = e;
              else if (v.mode != 0) acc += e;
              else if (e > acc)     acc = e;
            end
          end
          exp_wa.push_back((v.wb + orr * ocols + occ) & 'hFFF);
          exp_wd.push_back((v.mode != 0) ? (acc >>> sh) : acc);
        end
      end
    end
    stall_en = (v.stall != 0);
    start_job(v);
    check({tag, "_cfg_err"}, int'(cfg_err), v.exp_err);
    check({tag, "_busy_after_start"}, int'(busy), (v.exp_err != 0) ? 0 : 1);
    if (v.exp_err != 0) begin
      seen = 0;
      repeat (6) begin
        @(posedge clk); #1;
        seen = seen | int'(rd_req) | int'(busy) | int'(cfg_err) | int'(wr_req);
      end
      check({tag, "_quiet_after_reject"}, seen, 0);
      check({tag, "_reads_after_reject"}, rd_q.size(), 0);
    end else begin
      cyc  = 0;
      gaps = 0;
      while (!done && cyc < 5000) begin
        if (!busy) gaps++;
        if (repulse && cyc == 5) begin
          sw_wr_addr = 12'h7F0;
          sw_start   = 1'b1;
        end
        @(posedge clk); #1;
        sw_start = 1'b0;
        cyc++;
      end
      check({tag, "_done_seen"}, int'(done), 1);
      check({tag, "_busy_low_at_done"}, int'(busy), 0);
      check({tag, "_busy_gaps"}, gaps, 0);
      @(posedge clk); #1;
      check({tag, "_done_single"}, int'(done), 0);
      check({tag, "_rd_count"}, rd_q.size(), exp_rd.size());
      for (int k = 0; k < exp_rd.size() && k < rd_q.size(); k++)
        check($sformatf("%s_rd_addr%0d", tag, k), rd_q[k], exp_rd[k]);
      check({tag, "_wr_count"}, wa_q.size(), v.exp_nwr);
      for (int k = 0; k < exp_wa.size() && k < wa_q.size(); k++) begin
        check($sformatf("%s_wr_addr%0d", tag, k), wa_q[k], exp_wa[k]);
        check($sformatf("%s_wr_data%0d", tag, k), wd_q[k], exp_wd[k]);
      end
      if (wd_q.size() > 0) begin
        check({tag, "_first_result"}, wd_q[0], v.exp_first);
        check({tag, "_last_result"}, wd_q[wd_q.size()-1], v.exp_last);
      end
    end
  endtask

  vec_t vecs[13];

  initial begin
    int cyc, seen;
    //         rows cols wm wn mode rb     wb     fill stall err nwr first last
    vecs[0]  = '{4, 4, 2, 2, 0, 'h100, 'h200, 0, 0, 0, 4,   5,  15};
    vecs[1]  = '{4, 4, 2, 2, 1, 'h100, 'h210, 1, 0, 0, 4,  -3,  -3};
    vecs[2]  = '{5, 3, 2, 2, 0, 'h300, 'h220, 0, 0, 0, 2,   4,  10};
    vecs[3]  = '{3, 3, 3, 1, 1, 'h100, 'h230, 0, 0, 1, 0,   0,   0};
    vecs[4]  = '{4, 4, 2, 0, 0, 'h100, 'h230, 0, 0, 1, 0,   0,   0};
    vecs[5]  = '{8, 8, 5, 1, 0, 'h100, 'h230, 0, 0, 1, 0,   0,   0};
    vecs[6]  = '{1, 4, 2, 1, 0, 'h100, 'h230, 0, 0, 1, 0,   0,   0};
    vecs[7]  = '{4, 4, 2, 2, 0, 'hFFE, 'h240, 0, 0, 0, 4,   5,  15};
    vecs[8]  = '{4, 8, 2, 4, 1, 'h400, 'h250, 0, 1, 0, 4,   5,  25};
    vecs[9]  = '{3, 2, 1, 1, 1, 'h500, 'h260, 2, 0, 0, 6,  -5, -30};
    vecs[10] = '{3, 3, 3, 3, 0, 'h600, 'h270, 2, 1, 0, 1,  -5,  -5};
    vecs[11] = '{8, 8, 2, 2, 1, 'h700, 'h280, 3, 1, 0, 16, -90, 52};
    vecs[12] = '{4, 2, 1, 4, 0, 'h100, 'h230, 0, 0, 1, 0,   0,   0};

    for (int i = 0; i < 4096; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_cfg_err", int'(cfg_err), 0);
    check("reset_rd_req", int'(rd_req), 0);
    check("reset_wr_req", int'(wr_req), 0);
    check("reset_rd_addr", int'(rd_addr), 0);
    check("reset_wr_addr", int'(wr_addr), 0);
    check("reset_wr_data", int'(wr_data), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_job(vecs[i], i, 1'b0);

    // sw_start with a different write base while busy must not disturb the job.
    run_job(vecs[0], 20, 1'b1);

    // Reset while a read is outstanding; its late return must be ignored.
    lat_cfg  = 5;
    stall_en = 1'b0;
    for (int i = 0; i < 16; i++) mem[(vecs[0].rb + i) & 'hFFF] = 8'(i);
    start_job(vecs[0]);
    cyc = 0;
    while (!(busy && !rd_req) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_mid_reached_rd_wait", int'(busy && !rd_req), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_rd_req", int'(rd_req), 0);
    check("rst_mid_wr_req", int'(wr_req), 0);
    check("rst_mid_done", int'(done), 0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      seen = seen | int'(busy) | int'(rd_req) | int'(wr_req) | int'(done);
    end
    check("rst_mid_late_valid_ignored", seen, 0);
    lat_cfg = 1;
    run_job(vecs[0], 21, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool_engine.md
Name: pool_engine

Overview:
- Parametrised pooling engine for the CNN datapath.
- Reads a signed DATA_W-bit matrix from memory one element per access and applies a non-overlapping WIN_M x WIN_N window with stride equal to the window.
- Computes max or average per window and writes one result per window.
- Replaces the fixed single-mode pool unit; adds selectable mode, runtime window size, config checking and done/error reporting.

Parameters:
- ADDR_WIDTH, 12, memory word address width.
- DATA_W, 8, element width; elements are signed two's complement.
- DIM_W, 8, width of the matrix row/column count fields.
- MAX_WIN, 4, largest legal window dimension.
- WIN_W, $clog2(MAX_WIN+1), width of the window size fields.
- ACC_W, DATA_W+2*$clog2(MAX_WIN), width of the signed average accumulator.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- sw_start  in  1  single-cycle start pulse
- sw_rd_addr  in  ADDR_WIDTH  base address of the input matrix
- sw_wr_addr  in  ADDR_WIDTH  base address of the output matrix
- sw_rows / sw_cols  in  DIM_W  input matrix dimensions
- sw_win_m / sw_win_n  in  WIN_W  window rows / columns
- sw_mode  in  1  0 = max, 1 = average
- busy  out  1  job in progress
- done  out  1  one-cycle pulse when the job completes
- cfg_err  out  1  one-cycle pulse when a start is rejected
- rd_req / rd_addr  out  1 / ADDR_WIDTH  read request and address
- rd_gnt  in  1  read request accepted
- rd_valid / rd_data  in  1 / DATA_W  read data return
- wr_req / wr_addr / wr_data  out  1 / ADDR_WIDTH / DATA_W  write request, address and data
- wr_gnt  in  1  write accepted

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters 0. Reset is synchronous, active-low.
- Configuration capture:
  - sw_start is sampled only in IDLE; all sw_* fields are registered on that cycle.
  - sw_start while busy is ignored.
- Configuration check:
  - Reject if win_m or win_n is 0 or exceeds MAX_WIN.
  - Reject if rows < win_m or cols < win_n.
  - In average mode, reject if win_m*win_n is not a power of two.
  - On rejection: cfg_err pulses the cycle after start, busy stays 0, no memory access is issued.
- Output dimensions:
  - out_rows = floor(rows/win_m), out_cols = floor(cols/win_n).
  - Trailing rows and columns that do not fill a window are never read.
- FSM states: IDLE, RD_REQ, RD_WAIT, ACC, WR, DONE.
  - IDLE -> RD_REQ on an accepted start.
  - RD_REQ: rd_req held high with a stable rd_addr until rd_gnt, then -> RD_WAIT.
  - RD_WAIT -> ACC on rd_valid. Only one read is outstanding at a time.
  - ACC: after the last element of the window -> WR, otherwise -> RD_REQ.
  - WR: wr_req held high with stable address and data until wr_gnt. Then -> RD_REQ for the next window, or -> DONE after the last window.
  - DONE: done pulses for 1 cycle, then -> IDLE.
- busy is 1 in every state except IDLE. It falls in the same cycle done is high.
- Read order: window-row-major inside a window, windows row-major across the matrix.
  - Element address = rd_base + (out_r*win_m + wr_i)*cols + out_c*win_n + wc_i.
  - Addresses are computed modulo 2^ADDR_WIDTH (wrap is legal and silent).
- Write address = wr_base + out_r*out_cols + out_c.
- Max mode: the first element of each window initialises the running max; the comparison is signed.
- Average mode:
  - Sum is sign-extended into ACC_W bits.
  - Result = sum >>> log2(win_m*win_n), an arithmetic shift, so rounding is floor toward -inf.
  - The low DATA_W bits of the result are written; the mean always fits, so no saturation is needed.
- Timing:
  - rd_valid is never asserted in the same cycle as its rd_gnt; the minimum read latency is 1 cycle.
  - rd_valid outside RD_WAIT is ignored.
- Reset mid-job: the next cycle is IDLE with all outputs 0. A late rd_valid after reset is ignored. A request that was granted is not reissued.
- A 1x1 window is legal: the output is a copy of the input.

Decomposition:
- pool_pkg holds:
  - the state enum typedef pool_state_e;
  - the mode constants POOL_MAX and POOL_AVG;
  - the function log2_pow2() with its is-power-of-two check.
- Sub-module pool_addr_gen holds the four nested counters (wc_i, wr_i, out_c, out_r) and both address computations. It has step and restart inputs and last_elem, last_win, rd_addr and wr_addr outputs.
- The arithmetic and FSM stay in pool_engine.

Test Plan:
- Max pooling, 4x4 input of 0..15, 2x2 window, always-grant memory, 1-cycle read latency -> writes 5, 7, 13, 15 to wr_base+0..3; done pulses once; busy is high throughout.
- Average, 4x4 input of all -3 except the first element = -2, 2x2 window -> first output floor(-11/4) = -3, others -3; 16 reads and 4 writes total.
- Configuration rejects: 5x3 with a 2x2 window -> out 2x1, reads never touch row 4 or column 2; win_m=3, win_n=1 in average mode -> cfg_err pulse, no rd_req; win_n=0 -> cfg_err pulse, no rd_req.
- Backpressure: random rd_gnt/wr_gnt stalls and read latency 1..5 -> addresses and data stay stable while a request is pending; results match the reference model.
- sw_start re-pulsed mid-job is ignored; rst_n low for 1 cycle mid-job -> IDLE next cycle, a following late rd_valid is ignored, and a new job completes correctly.
- rd_base=0xFFE with a 2x2 window -> addresses wrap to 0x000 and the results stay correct.
